// File: rtl/num_display_fmt.sv
// Number-to-display-cell formatter: one calc_pkg::num_t in, NumDigits+1 cell codes out, MSB cell first.
// Latency: accept -> align (1 cycle + 1 per right-shift digit) -> first beat loaded 1 cycle later.
// Backpressure: output beats are held stable while out_ready_i=0; input is only accepted in S_IDLE.
// Optional feature: define NUM_DISPLAY_TRIM_ZEROS_EN to blank trailing fractional zeros.

package calc_pkg;
  localparam int NumDigits = 8;
  localparam int ExpWidth  = 6;

  // Significand is packed BCD, digit 0 in the low nibble.
  typedef struct packed {
    logic                   error;
    logic                   sign;
    logic [ExpWidth-1:0]    exponent;
    logic [4*NumDigits-1:0] significand;
  } num_t;
endpackage

module num_display_fmt #(
  // Value = significand * 10^(exponent - EXP_BIAS); must be >= NumDigits-1.
  parameter int EXP_BIAS = 9
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  calc_pkg::num_t  num_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  output logic [3:0]      char_o,
  output logic            dp_o,
  output logic            last_o,
  output logic            out_valid_o,
  input  logic            out_ready_i
);

  localparam int ND = calc_pkg::NumDigits;
  localparam int EW = calc_pkg::ExpWidth;
  localparam int CW = $clog2(ND + 1);

  localparam logic [EW-1:0] BIAS      = EW'(EXP_BIAS);
  localparam logic [EW-1:0] MAX_F     = EW'(ND - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(ND);

  localparam logic [3:0] C_BLANK = 4'hA;
  localparam logic [3:0] C_MINUS = 4'hB;
  localparam logic [3:0] C_E     = 4'hE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_EMIT
  } state_t;

  state_t          state_q;
  logic            sign_q;
  logic            ovf_q;
  logic [4*ND-1:0] sig_q;
  logic [EW-1:0]   exp_q;
  logic [EW-1:0]   frac_q;
  logic [CW-1:0]   cnt_q;

  // Fractional digit count for the number currently being aligned.
  logic [EW-1:0] frac_a;
  assign frac_a = BIAS - exp_q;

  // Beat to load next: the current one when nothing is presented yet, otherwise the following one.
  logic [CW-1:0] sel_k;
  assign sel_k = out_valid_o ? (cnt_q + 1'b1) : cnt_q;

  logic [ND-1:0] dig_zero;
  logic [ND-1:0] upper_zero;

  // Per-digit zero flags and "this digit and everything above it is zero" for leading-zero blanking.
  always_comb begin
    for (int i = 0; i < ND; i++) begin
      dig_zero[i] = (sig_q[4*i +: 4] == 4'h0);
    end
    upper_zero[ND-1] = dig_zero[ND-1];
    for (int i = ND - 2; i >= 0; i--) begin
      upper_zero[i] = dig_zero[i] & upper_zero[i+1];
    end
  end

  logic dp_en;

`ifdef NUM_DISPLAY_TRIM_ZEROS_EN
  logic [ND-1:0] lower_zero;
  logic          frac_nonzero;

  // Trailing-zero run from digit 0 upward, and whether any fractional digit is non-zero.
  always_comb begin
    lower_zero[0] = dig_zero[0];
    for (int i = 1; i < ND; i++) begin
      lower_zero[i] = dig_zero[i] & lower_zero[i-1];
    end
    frac_nonzero = 1'b0;
    for (int i = 0; i < ND; i++) begin
      if ((EW'(i) < frac_q) && !dig_zero[i]) frac_nonzero = 1'b1;
    end
  end

  assign dp_en = frac_nonzero;
`else
  assign dp_en = 1'b1;
`endif

  logic [3:0] beat_char;
  logic       beat_dp;
  logic       beat_last;

  // Cell code, decimal point and last flag for beat sel_k (0 = sign cell, then digits ND-1..0).
  always_comb begin
    beat_char = C_BLANK;
    beat_dp   = 1'b0;
    beat_last = (sel_k == LAST_BEAT);
    if (sel_k == '0) begin
      if (!ovf_q && sign_q && (sig_q != '0)) beat_char = C_MINUS;
    end
    for (int i = 0; i < ND; i++) begin
      if (sel_k == CW'(ND - i)) begin
        if (ovf_q) begin
          beat_char = (i == ND - 1) ? C_E : C_BLANK;
        end else if ((EW'(i) > frac_q) && upper_zero[i]) begin
          beat_char = C_BLANK;
`ifdef NUM_DISPLAY_TRIM_ZEROS_EN
        end else if ((EW'(i) < frac_q) && lower_zero[i]) begin
          beat_char = C_BLANK;
`endif
        end else begin
          beat_char = sig_q[4*i +: 4];
        end
        beat_dp = !ovf_q && (EW'(i) == frac_q) && (frac_q != '0) && dp_en;
      end
    end
  end

  // Control FSM: capture, digit alignment, and registered beat emission.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      char_o      <= 4'h0;
      dp_o        <= 1'b0;
      last_o      <= 1'b0;
      sign_q      <= 1'b0;
      ovf_q       <= 1'b0;
      sig_q       <= '0;
      exp_q       <= '0;
      frac_q      <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i && in_ready_o) begin
            sign_q     <= num_i.sign;
            sig_q      <= num_i.significand;
            exp_q      <= num_i.exponent;
            ovf_q      <= num_i.error;
            in_ready_o <= 1'b0;
            state_q    <= S_ALIGN;
          end
        end

        S_ALIGN: begin
          if (ovf_q || (exp_q > BIAS)) begin
            ovf_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_EMIT;
          end else if (frac_a > MAX_F) begin
            // Too many fractional digits to show: drop the lowest one.
            sig_q <= sig_q >> 4;
            exp_q <= exp_q + 1'b1;
          end else begin
            frac_q  <= frac_a;
            cnt_q   <= '0;
            state_q <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (!out_valid_o) begin
            out_valid_o <= 1'b1;
            char_o      <= beat_char;
            dp_o        <= beat_dp;
            last_o      <= beat_last;
          end else if (out_ready_i) begin
            if (last_o) begin
              out_valid_o <= 1'b0;
              char_o      <= 4'h0;
              dp_o        <= 1'b0;
              last_o      <= 1'b0;
              in_ready_o  <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              cnt_q  <= sel_k;
              char_o <= beat_char;
              dp_o   <= beat_dp;
              last_o <= beat_last;
            end
          end
        end

        default: begin
          state_q     <= S_IDLE;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_num_display_fmt.sv
// Directed bench for num_display_fmt: table of numbers with expected cell streams,
// plus backpressure / ignored-input and asynchronous mid-stream reset sequences.
module tb_num_display_fmt;
  import calc_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  num_t        num_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  char_o;
  logic        dp_o;
  logic        last_o;
  logic        out_valid_o;
  logic        out_ready_i;

  int checks = 0;
  int errors = 0;

  num_display_fmt #(.EXP_BIAS(9)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .num_i       (num_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .char_o      (char_o),
    .dp_o        (dp_o),
    .last_o      (last_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string        name;
    logic         err;
    logic         sgn;
    logic [5:0]   ex;
    logic [31:0]  sig;
    logic [35:0]  cells;  // cell 0 in the top nibble
    logic [8:0]   dps;    // cell 0 in the top bit
    int           lat;    // clock edges from accept to first valid beat
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  // Feed one number and check its whole cell stream. stall_beat >= 0 holds out_ready_i low
  // for 5 cycles on that beat; poke additionally drives a second number during the stall.
  task automatic run_vec(input vec_t v, input int stall_beat, input bit poke);
    int n;
    int lat;
    logic [3:0] ec;
    logic       ed;
    n = 0;
    while (!in_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk({v.name, " ready_before"}, in_ready_o, 1);
    num_i.error       = v.err;
    num_i.sign        = v.sgn;
    num_i.exponent    = v.ex;
    num_i.significand = v.sig;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    lat = 0;
    while (!out_valid_o && lat < 50) begin
      @(negedge clk_i);
      lat++;
    end
    chk({v.name, " latency"}, lat, v.lat);
    chk({v.name, " ready_busy"}, in_ready_o, 0);
    for (int k = 0; k < 9; k++) begin
      ec = v.cells[4*(8-k) +: 4];
      ed = v.dps[8-k];
      chk($sformatf("%s beat%0d", v.name, k), {out_valid_o, char_o, dp_o, last_o},
          {1'b1, ec, ed, (k == 8)});
      if (k == stall_beat) begin
        out_ready_i = 1'b0;
        if (poke) begin
          num_i.error       = 1'b1;
          num_i.significand = 32'h99999999;
          in_valid_i        = 1'b1;
        end
        repeat (5) begin
          @(negedge clk_i);
          chk($sformatf("%s stall%0d", v.name, k), {out_valid_o, char_o, dp_o, last_o, in_ready_o},
              {1'b1, ec, ed, (k == 8), 1'b0});
        end
        out_ready_i = 1'b1;
      end
      if (k == 7) in_valid_i = 1'b0;
      @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    chk({v.name, " done"}, {out_valid_o, in_ready_o, char_o, dp_o, last_o}, {1'b0, 1'b1, 4'h0, 1'b0, 1'b0});
    repeat (2) begin
      @(negedge clk_i);
      chk({v.name, " quiet"}, out_valid_o, 0);
    end
  endtask

  initial begin
    vecs[0] = '{"neg_f2",    1'b0, 1'b1, 6'd7,  32'h00001234, 36'hBAAAA1234, 9'b000000100, 2};
    vecs[1] = '{"shift2",    1'b0, 1'b0, 6'd0,  32'h12345678, 36'hA00123456, 9'b010000000, 4};
    vecs[2] = '{"exp_ovf",   1'b0, 1'b0, 6'd10, 32'h00001234, 36'hAEAAAAAAA, 9'b000000000, 2};
    vecs[3] = '{"err_ovf",   1'b1, 1'b1, 6'd7,  32'h00001234, 36'hAEAAAAAAA, 9'b000000000, 2};
`ifdef NUM_DISPLAY_TRIM_ZEROS_EN
    vecs[4] = '{"tail00",    1'b0, 1'b0, 6'd6,  32'h00012500, 36'hAAAA125AA, 9'b000001000, 2};
`else
    vecs[4] = '{"tail00",    1'b0, 1'b0, 6'd6,  32'h00012500, 36'hAAAA12500, 9'b000001000, 2};
`endif
    vecs[5] = '{"neg_zero",  1'b0, 1'b1, 6'd9,  32'h00000000, 36'hAAAAAAAA0, 9'b000000000, 2};
    vecs[6] = '{"neg_int",   1'b0, 1'b1, 6'd9,  32'h87654321, 36'hB87654321, 9'b000000000, 2};
`ifdef NUM_DISPLAY_TRIM_ZEROS_EN
    vecs[7] = '{"frac_zero", 1'b0, 1'b0, 6'd7,  32'h00000500, 36'hAAAAAA5AA, 9'b000000000, 2};
`else
    vecs[7] = '{"frac_zero", 1'b0, 1'b0, 6'd7,  32'h00000500, 36'hAAAAAA500, 9'b000000100, 2};
`endif
    vecs[8] = '{"neg_f7",    1'b0, 1'b1, 6'd2,  32'h00000005, 36'hB00000005, 9'b010000000, 2};
`ifdef NUM_DISPLAY_TRIM_ZEROS_EN
    vecs[9] = '{"trunc_0",   1'b0, 1'b1, 6'd0,  32'h00000009, 36'hA0AAAAAAA, 9'b000000000, 4};
`else
    vecs[9] = '{"trunc_0",   1'b0, 1'b1, 6'd0,  32'h00000009, 36'hA00000000, 9'b010000000, 4};
`endif

    rst_i       = 1'b1;
    num_i       = '0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("reset_state", {in_ready_o, out_valid_o, char_o, dp_o, last_o}, {1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], -1, 1'b0);
    end

    // Backpressure on beat 3 with a second number offered during the stall.
    run_vec(vecs[0], 3, 1'b1);
    // Backpressure on the decimal-point beat.
    run_vec(vecs[4], 5, 1'b0);

    // Asynchronous reset in the middle of a stream.
    num_i.error       = 1'b0;
    num_i.sign        = 1'b0;
    num_i.exponent    = 6'd0;
    num_i.significand = 32'h12345678;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    chk("pre_reset_streaming", {out_valid_o, char_o}, {1'b1, 4'h0});
    #2 rst_i = 1'b1;
    #1;
    chk("async_reset", {out_valid_o, in_ready_o, char_o, dp_o, last_o}, {1'b0, 1'b1, 4'h0, 1'b0, 1'b0});
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      chk("post_reset_quiet", {out_valid_o, in_ready_o}, {1'b0, 1'b1});
    end
    run_vec(vecs[4], -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
